mc_controller: RTL and testbench

Parametrised multicycle control FSM for the 16-bit CR16-style datapath. It decodes `op`/`op_ext`, evaluates branch conditions against the PSR, and drives all datapath mux selects and enables. Unlike the fixed single-cycle-memory controller, it stretches every memory access over `MEM_LAT` cycles using an internal wait counter. It traps undecodable instructions in a sticky `ILLEGAL` state and optionally supports a vectored interrupt.

---
 rtl/mc_controller.sv | 254 +++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle control FSM for the 16-bit CR16-style datapath; memory states are stretched over MEM_LAT cycles.
// Optional vectored interrupt support is enabled by defining CTRL_IRQ_EN.
module mc_controller #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic [3:0] op_ext,
  input  logic [3:0] branch_cond,
  input  logic [4:0] psr,
  output logic [1:0] wd_s,
  output logic [1:0] alua_s,
  output logic [1:0] alub_s,
  output logic [1:0] mem_data_s,
  output logic       pc_s,
  output logic       pc_en,
  output logic       reg_wr_en,
  output logic       instr_en,
  output logic       alu_out_en,
  output logic       mem_reg_en,
  output logic       mem_wr_s,
  output logic       mem_s,
  output logic       se_sign,
  output logic       psr_en,
  output logic       illegal,
  output logic [4:0] state
`ifdef CTRL_IRQ_EN
  ,
  input  logic       irq,
  output logic       irq_ack,
  output logic       pc_vec_s,
  output logic       link_s
`endif
);

  typedef enum logic [4:0] {
    FETCH      = 5'd0,
    DECODE     = 5'd1,
    RTYPE_EX   = 5'd2,
    ITYPE_EX   = 5'd3,
    WRITE      = 5'd4,
    LB_MEM     = 5'd5,
    LB_LOAD    = 5'd6,
    SB_MEM_R   = 5'd7,
    SB_MEM_I   = 5'd8,
    CALC_DISP  = 5'd9,
    PC_UP      = 5'd10,
    JUMP       = 5'd11,
    CALC_RLINK = 5'd12,
    WR_RLINK_J = 5'd13,
    ILLEGAL    = 5'd14
`ifdef CTRL_IRQ_EN
    ,
    IRQ_SAVE   = 5'd15,
    IRQ_VEC    = 5'd16
`endif
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_LAT - 1);

  state_t           state_q, state_d, fetch_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_done, in_mem, cond;
  logic             n_f, z_f, f_f, l_f, c_f;

  assign {n_f, z_f, f_f, l_f, c_f} = psr;
  assign wait_done = (cnt_q == LAST);
  assign in_mem    = (state_q == FETCH) || (state_q == LB_MEM) ||
                     (state_q == SB_MEM_R) || (state_q == SB_MEM_I);

`ifdef CTRL_IRQ_EN
  // Interrupts are only taken at instruction boundaries, never out of IRQ_VEC.
  assign fetch_nxt = irq ? IRQ_SAVE : FETCH;
`else
  assign fetch_nxt = FETCH;
`endif

  always_comb begin
    cond = 1'b0;
    case (branch_cond)
      4'b0000: cond = z_f;
      4'b0001: cond = !z_f;
      4'b0010: cond = c_f;
      4'b0011: cond = !c_f;
      4'b0100: cond = l_f;
      4'b0101: cond = !l_f;
      4'b0110: cond = n_f;
      4'b0111: cond = !n_f;
      4'b1000: cond = f_f;
      4'b1001: cond = !f_f;
      4'b1010: cond = !l_f && !z_f;
      4'b1011: cond = l_f || z_f;
      4'b1100: cond = !n_f && !z_f;
      4'b1101: cond = n_f || z_f;
      4'b1110: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (wait_done) state_d = DECODE;
      DECODE: begin
        case (op)
          4'b0000: state_d = RTYPE_EX;
          4'b0100: begin
            case (op_ext)
              4'b0100: state_d = SB_MEM_R;
              4'b0000: state_d = LB_MEM;
              4'b1100: state_d = cond ? JUMP : PC_UP;
              4'b1000: state_d = CALC_RLINK;
              default: state_d = ILLEGAL;
            endcase
          end
          4'b1000: state_d = (op_ext == 4'b0100) ? RTYPE_EX : ITYPE_EX;
          4'b1100: state_d = cond ? CALC_DISP : PC_UP;
          default: state_d = ITYPE_EX;
        endcase
      end
      RTYPE_EX: state_d = (op_ext == 4'b1011) ? PC_UP : WRITE;
      ITYPE_EX: begin
        if (op == 4'b1011)      state_d = PC_UP;
        else if (op == 4'b0111) state_d = SB_MEM_I;
        else                    state_d = WRITE;
      end
      WRITE, LB_LOAD:     state_d = PC_UP;
      SB_MEM_R, SB_MEM_I: if (wait_done) state_d = PC_UP;
      LB_MEM:             if (wait_done) state_d = LB_LOAD;
      CALC_RLINK:         state_d = WR_RLINK_J;
      CALC_DISP, JUMP, WR_RLINK_J, PC_UP: state_d = fetch_nxt;
      ILLEGAL:            state_d = ILLEGAL;
`ifdef CTRL_IRQ_EN
      IRQ_SAVE:           state_d = IRQ_VEC;
      IRQ_VEC:            state_d = FETCH;
`endif
      default:            state_d = ILLEGAL;
    endcase
  end

  // Counter restarts at 0 on every entry and counts only while a memory state holds.
  assign cnt_d = (in_mem && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    wd_s       = 2'b00;
    alua_s     = 2'b00;
    alub_s     = 2'b00;
    mem_data_s = 2'b00;
    pc_s       = 1'b0;
    pc_en      = 1'b0;
    reg_wr_en  = 1'b0;
    instr_en   = 1'b0;
    alu_out_en = 1'b0;
    mem_reg_en = 1'b0;
    mem_wr_s   = 1'b0;
    mem_s      = 1'b0;
    se_sign    = 1'b1;
    psr_en     = 1'b0;
    illegal    = 1'b0;
`ifdef CTRL_IRQ_EN
    irq_ack    = 1'b0;
    pc_vec_s   = 1'b0;
    link_s     = 1'b0;
`endif
    // Reset gating keeps stale strobes from leaking out while reset is held.
    if (reset) begin
      case (state_q)
        FETCH: begin
          mem_s    = 1'b1;
          instr_en = wait_done;
        end
        RTYPE_EX: begin
          alu_out_en = 1'b1;
          psr_en     = 1'b1;
        end
        ITYPE_EX: begin
          alu_out_en = 1'b1;
          psr_en     = 1'b1;
          alua_s     = 2'b10;
          se_sign    = !((op == 4'b0001) || (op == 4'b0010) || (op == 4'b0011));
        end
        WRITE: begin
          wd_s      = 2'b11;
          reg_wr_en = 1'b1;
        end
        LB_MEM: begin
          wd_s       = 2'b10;
          mem_reg_en = wait_done;
        end
        LB_LOAD: begin
          wd_s      = 2'b10;
          reg_wr_en = 1'b1;
        end
        SB_MEM_R: mem_wr_s = (cnt_q == '0);
        SB_MEM_I: begin
          mem_wr_s   = (cnt_q == '0);
          mem_data_s = 2'b01;
        end
        CALC_DISP: begin
          alua_s = 2'b01;
          alub_s = 2'b01;
          pc_s   = 1'b1;
          pc_en  = 1'b1;
        end
        PC_UP: begin
          alua_s = 2'b01;
          alub_s = 2'b10;
          pc_s   = 1'b1;
          pc_en  = 1'b1;
        end
        JUMP: pc_en = 1'b1;
        CALC_RLINK: begin
          alua_s     = 2'b01;
          alub_s     = 2'b10;
          alu_out_en = 1'b1;
        end
        WR_RLINK_J: begin
          wd_s      = 2'b11;
          reg_wr_en = 1'b1;
          pc_en     = 1'b1;
        end
        ILLEGAL: illegal = 1'b1;
`ifdef CTRL_IRQ_EN
        IRQ_SAVE: begin
          wd_s      = 2'b01;
          link_s    = 1'b1;
          reg_wr_en = 1'b1;
        end
        IRQ_VEC: begin
          pc_en    = 1'b1;
          pc_vec_s = 1'b1;
          irq_ack  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = reset ? state_q : 5'd0;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller (MEM_LAT=3): per-cycle control words are predicted from instruction class and latency.
module tb_mc_controller;
  localparam int L = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] op = '0, op_ext = '0, branch_cond = '0;
  logic [4:0] psr = '0;
  logic [1:0] wd_s, alua_s, alub_s, mem_data_s;
  logic       pc_s, pc_en, reg_wr_en, instr_en, alu_out_en, mem_reg_en;
  logic       mem_wr_s, mem_s, se_sign, psr_en, illegal;
  logic [4:0] state;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [1:0] wd, alua, alub, mds;
    logic pcs, pcen, rwe, ien, aoe, mre, mws, ms, se, psre, ill;
  } ctl_t;

  ctl_t act;
  ctl_t exp_q[$];

  mc_controller #(.MEM_LAT(L), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .op_ext(op_ext), .branch_cond(branch_cond), .psr(psr),
    .wd_s(wd_s), .alua_s(alua_s), .alub_s(alub_s), .mem_data_s(mem_data_s),
    .pc_s(pc_s), .pc_en(pc_en), .reg_wr_en(reg_wr_en), .instr_en(instr_en),
    .alu_out_en(alu_out_en), .mem_reg_en(mem_reg_en), .mem_wr_s(mem_wr_s), .mem_s(mem_s),
    .se_sign(se_sign), .psr_en(psr_en), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {wd_s, alua_s, alub_s, mem_data_s, pc_s, pc_en, reg_wr_en, instr_en,
                alu_out_en, mem_reg_en, mem_wr_s, mem_s, se_sign, psr_en, illegal};

  function automatic ctl_t dflt();
    ctl_t c;
    c = '0;
    c.se = 1'b1;
    return c;
  endfunction

  function automatic bit taken(input logic [3:0] bc, input logic [4:0] p);
    bit n, z, f, lo, c;
    {n, z, f, lo, c} = p;
    case (bc)
      4'd0: return z;         4'd1: return !z;
      4'd2: return c;         4'd3: return !c;
      4'd4: return lo;        4'd5: return !lo;
      4'd6: return n;         4'd7: return !n;
      4'd8: return f;         4'd9: return !f;
      4'd10: return !lo && !z; 4'd11: return lo || z;
      4'd12: return !n && !z;  4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // kind: 0 fetch, 1 LB access, 2 SB reg data, 3 SB imm data
  task automatic push_mem(input int kind);
    ctl_t c;
    for (int i = 0; i < L; i++) begin
      c = dflt();
      case (kind)
        0: begin c.ms = 1'b1; c.ien = (i == L-1); end
        1: begin c.wd = 2'd2; c.mre = (i == L-1); end
        2: c.mws = (i == 0);
        default: begin c.mws = (i == 0); c.mds = 2'd1; end
      endcase
      exp_q.push_back(c);
    end
  endtask

  task automatic push_pcup();
    ctl_t c = dflt();
    c.alua = 2'd1; c.alub = 2'd2; c.pcs = 1'b1; c.pcen = 1'b1;
    exp_q.push_back(c);
  endtask

  task automatic push_write();
    ctl_t c = dflt();
    c.wd = 2'd3; c.rwe = 1'b1;
    exp_q.push_back(c);
  endtask

  task automatic build(input logic [3:0] o, input logic [3:0] e, input logic [3:0] bc, input logic [4:0] p);
    ctl_t c;
    exp_q.delete();
    push_mem(0);
    exp_q.push_back(dflt());
    if (o == 4'd0 || (o == 4'd8 && e == 4'd4)) begin
      c = dflt(); c.aoe = 1'b1; c.psre = 1'b1; exp_q.push_back(c);
      if (e != 4'd11) push_write();
      push_pcup();
    end else if (o == 4'd4) begin
      case (e)
        4'd4: begin push_mem(2); push_pcup(); end
        4'd0: begin
          push_mem(1);
          c = dflt(); c.wd = 2'd2; c.rwe = 1'b1; exp_q.push_back(c);
          push_pcup();
        end
        4'd12: begin
          if (taken(bc, p)) begin c = dflt(); c.pcen = 1'b1; exp_q.push_back(c); end
          else push_pcup();
        end
        4'd8: begin
          c = dflt(); c.alua = 2'd1; c.alub = 2'd2; c.aoe = 1'b1; exp_q.push_back(c);
          c = dflt(); c.wd = 2'd3; c.rwe = 1'b1; c.pcen = 1'b1; exp_q.push_back(c);
        end
        default: begin
          c = dflt(); c.ill = 1'b1;
          repeat (20) exp_q.push_back(c);
        end
      endcase
    end else if (o == 4'd12) begin
      if (taken(bc, p)) begin
        c = dflt(); c.alua = 2'd1; c.alub = 2'd1; c.pcs = 1'b1; c.pcen = 1'b1; exp_q.push_back(c);
      end else push_pcup();
    end else begin
      c = dflt(); c.alua = 2'd2; c.aoe = 1'b1; c.psre = 1'b1;
      c.se = !(o == 4'd1 || o == 4'd2 || o == 4'd3);
      exp_q.push_back(c);
      if (o == 4'd11) push_pcup();
      else if (o == 4'd7) begin push_mem(3); push_pcup(); end
      else begin push_write(); push_pcup(); end
    end
  endtask

  // Entered at a negedge in the first FETCH cycle; a full run leaves at the next one.
  task automatic run_instr(input string nm, input logic [3:0] o, input logic [3:0] e,
                           input logic [3:0] bc, input logic [4:0] p, input int max_cyc);
    int n;
    op = o; op_ext = e; branch_cond = bc; psr = p;
    build(o, e, bc, p);
    n = (max_cyc < exp_q.size()) ? max_cyc : exp_q.size();
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      vectors++;
      if (act !== exp_q[k]) begin
        miscompares++;
        $display("FAIL %s op=%h ext=%h bc=%h psr=%b cyc %0d: got %h want %h",
                 nm, o, e, bc, p, k, act, exp_q[k]);
      end
    end
    if (n == exp_q.size()) @(negedge clk);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++;
      if (act !== dflt() || state !== 5'd0) begin
        miscompares++;
        $display("FAIL %s in-reset cyc %0d: got ctl %h state %0d want ctl %h state 0",
                 nm, i, act, state, dflt());
      end
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset("reset");
    run_instr("post_reset_add", 4'd0, 4'd5, 4'd0, 5'd0, 1000);
  endtask

  task automatic test_alu();
    run_instr("add", 4'd0, 4'd5, 4'd0, 5'd0, 1000);
    run_instr("cmp", 4'd0, 4'd11, 4'd0, 5'd0, 1000);
    run_instr("andi", 4'd1, 4'd0, 4'd0, 5'd0, 1000);
    run_instr("addi", 4'd5, 4'd0, 4'd0, 5'd0, 1000);
    run_instr("cmpi", 4'd11, 4'd0, 4'd0, 5'd0, 1000);
    run_instr("rtype_op8", 4'd8, 4'd4, 4'd0, 5'd0, 1000);
    run_instr("itype_op8", 4'd8, 4'd1, 4'd0, 5'd0, 1000);
  endtask

  task automatic test_mem();
    run_instr("lb", 4'd4, 4'd0, 4'd0, 5'd0, 1000);
    run_instr("sb", 4'd4, 4'd4, 4'd0, 5'd0, 1000);
    run_instr("sbi", 4'd7, 4'd0, 4'd0, 5'd0, 1000);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 4'd12, 4'd0, 4'd0, 5'b01000, 1000);
    run_instr("beq_not", 4'd12, 4'd0, 4'd0, 5'b00000, 1000);
    run_instr("bnever", 4'd12, 4'd0, 4'd15, 5'b11111, 1000);
    run_instr("juc", 4'd4, 4'd12, 4'd14, 5'b00000, 1000);
    run_instr("jnever", 4'd4, 4'd12, 4'd15, 5'b11111, 1000);
    run_instr("jal", 4'd4, 4'd8, 4'd0, 5'd0, 1000);
  endtask

  task automatic test_random();
    logic [3:0] o, e, bc;
    logic [4:0] p;
    for (int i = 0; i < 60; i++) begin
      o  = 4'($urandom);
      e  = 4'($urandom);
      bc = 4'($urandom);
      p  = 5'($urandom);
      if (o == 4'd4) e[1:0] = 2'b00;
      run_instr("random", o, e, bc, p, 1000);
    end
  endtask

  task automatic test_illegal();
    run_instr("illegal", 4'd4, 4'd15, 4'd0, 5'd0, 1000);
    do_reset("illegal_reset");
    run_instr("after_illegal", 4'd0, 4'd5, 4'd0, 5'd0, 1000);
  endtask

  task automatic test_reset_mid_sb();
    // Stops after the store strobe; reset lands on the second access cycle.
    run_instr("sb_prefix", 4'd4, 4'd4, 4'd0, 5'd0, L + 2);
    do_reset("sb_mid_reset");
    run_instr("after_sb_reset", 4'd4, 4'd0, 4'd0, 5'd0, 1000);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_random();
    test_illegal();
    test_reset_mid_sb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
